// File: rtl/clock_speed_selector_pkg.sv
// Shared widths, conditioner state encoding and the factor clamp helper
// for the clock speed selector.
package clock_speed_selector_pkg;

    localparam int FACTOR_W           = 16;
    localparam int TIMER_W            = 32;
    localparam int MAX_FACTOR_DEFAULT = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } cond_state_t;

    function automatic logic [FACTOR_W-1:0] clamp_factor(
        input logic [FACTOR_W-1:0] value,
        input logic [FACTOR_W-1:0] lo,
        input logic [FACTOR_W-1:0] hi
    );
        logic [FACTOR_W-1:0] r;
        r = (value > hi) ? hi : value;
        if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_speed_selector_if.sv
// Preset-load and factor-status bus between a controller and the selector.
interface clock_speed_selector_if;
    import clock_speed_selector_pkg::*;

    logic                load_en;
    logic [FACTOR_W-1:0] load_value;
    logic [FACTOR_W-1:0] divider_factor;
    logic                factor_changed;
    logic                at_min;
    logic                at_max;

    modport master (
        output load_en,
        output load_value,
        input  divider_factor,
        input  factor_changed,
        input  at_min,
        input  at_max
    );

    modport slave (
        input  load_en,
        input  load_value,
        output divider_factor,
        output factor_changed,
        output at_min,
        output at_max
    );

endinterface

// File: rtl/clock_speed_selector_button_conditioner.sv
// One push button: 2-FF synchronizer, counter debounce and a
// press / hold / autorepeat FSM emitting single-cycle step pulses.
module clock_speed_selector_button_conditioner
    import clock_speed_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic btn,
    output logic step_pulse
);

    localparam int                 DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LOAD  = TIMER_W'(REPEAT_RATE - 1);

    logic [1:0]         sync_reg;
    logic               synced;
    logic               db_level_reg;
    logic [DB_W-1:0]    db_cnt_reg;
    cond_state_t        state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               step_reg, step_next;

    assign synced     = sync_reg[1];
    assign step_pulse = step_reg;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            db_level_reg <= 1'b0;
            db_cnt_reg   <= '0;
        end else if (synced == db_level_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
            db_level_reg <= synced;
            db_cnt_reg   <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            step_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        step_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (db_level_reg) begin
                    step_next  = 1'b1;
                    timer_next = DELAY_LOAD;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!db_level_reg) begin
                    state_next = ST_IDLE;
                end else if (timer_reg == '0) begin
                    step_next  = 1'b1;
                    timer_next = RATE_LOAD;
                    state_next = ST_REPEAT;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/clock_speed_selector.sv
// Saturating divider-factor register driven by two conditioned buttons
// and a preset load; load wins, opposing steps in one cycle cancel.
module clock_speed_selector
    import clock_speed_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int INIT_FACTOR     = 1,
    parameter int MIN_FACTOR      = 0,
    parameter int MAX_FACTOR      = MAX_FACTOR_DEFAULT
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  btn_up,
    input  logic                  btn_down,
    clock_speed_selector_if.slave ctrl
);

    localparam logic [FACTOR_W-1:0] INIT_F = FACTOR_W'(INIT_FACTOR);
    localparam logic [FACTOR_W-1:0] MIN_F  = FACTOR_W'(MIN_FACTOR);
    localparam logic [FACTOR_W-1:0] MAX_F  = FACTOR_W'(MAX_FACTOR);

    logic [1:0]          btn_raw;
    logic [1:0]          step;
    logic [FACTOR_W-1:0] factor_reg, factor_next;
    logic                changed_reg;

    // Index 0 raises the factor (slower clock), index 1 lowers it.
    assign btn_raw = {btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            clock_speed_selector_button_conditioner #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE)
            ) u_cond (
                .in_clk     (in_clk),
                .in_rst_n   (in_rst_n),
                .btn        (btn_raw[gi]),
                .step_pulse (step[gi])
            );
        end
    endgenerate

    always_comb begin
        factor_next = factor_reg;
        if (ctrl.load_en) begin
            factor_next = clamp_factor(ctrl.load_value, MIN_F, MAX_F);
        end else if (step[0] && !step[1]) begin
            factor_next = (factor_reg >= MAX_F) ? MAX_F : factor_reg + 1'b1;
        end else if (step[1] && !step[0]) begin
            factor_next = (factor_reg <= MIN_F) ? MIN_F : factor_reg - 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            factor_reg  <= INIT_F;
            changed_reg <= 1'b0;
        end else begin
            factor_reg  <= factor_next;
            changed_reg <= (factor_next != factor_reg);
        end
    end

    assign ctrl.divider_factor = factor_reg;
    assign ctrl.factor_changed = changed_reg;
    assign ctrl.at_min         = (factor_reg == MIN_F);
    assign ctrl.at_max         = (factor_reg == MAX_F);

endmodule

// File: tb/tb_clock_speed_selector.sv
// Bench for clock_speed_selector: load vector table, directed button
// sequences, and randomized traffic against a cycle-level reference model.
module tb_clock_speed_selector;
    import clock_speed_selector_pkg::*;

    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RR    = 5;
    localparam int INITF = 1;
    localparam int MAXF  = 26;

    logic in_clk   = 1'b0;
    logic in_rst_n = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;

    clock_speed_selector_if ctrl_if();

    clock_speed_selector #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .INIT_FACTOR     (INITF),
        .MIN_FACTOR      (0),
        .MAX_FACTOR      (MAXF)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .ctrl     (ctrl_if)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: button press age decides step instants.
    int m_factor = INITF;
    bit m_fc     = 1'b0;
    bit m_s0[2]  = '{0, 0};
    bit m_s1[2]  = '{0, 0};
    bit m_deb[2] = '{0, 0};
    int m_run[2] = '{0, 0};
    int m_age[2] = '{0, 0};
    bit m_pulse[2] = '{0, 0};

    always @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            m_factor = INITF;
            m_fc     = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_s0[b] = 0; m_s1[b] = 0; m_deb[b] = 0;
                m_run[b] = 0; m_age[b] = 0; m_pulse[b] = 0;
            end
        end else begin
            int old;
            bit raw[2];
            raw[0] = btn_up;
            raw[1] = btn_down;
            old = m_factor;
            if (ctrl_if.load_en) begin
                m_factor = (int'(ctrl_if.load_value) > MAXF) ? MAXF : int'(ctrl_if.load_value);
            end else if (m_pulse[0] && !m_pulse[1]) begin
                m_factor = (old + 1 > MAXF) ? MAXF : old + 1;
            end else if (m_pulse[1] && !m_pulse[0]) begin
                m_factor = (old - 1 < 0) ? 0 : old - 1;
            end
            m_fc = (m_factor != old);
            for (int b = 0; b < 2; b++) begin
                m_age[b]   = m_deb[b] ? m_age[b] + 1 : 0;
                m_pulse[b] = m_deb[b] && ((m_age[b] == 1) || (m_age[b] == 1 + RD) ||
                             ((m_age[b] > 1 + RD) && ((m_age[b] - 1 - RD) % RR == 0)));
                if (m_s1[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_deb[b] = m_s1[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s1[b] = m_s0[b];
                m_s0[b] = raw[b];
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge in_clk) begin
        if (chk_en) begin
            check("model_factor", ctrl_if.divider_factor, m_factor);
            check("model_changed", ctrl_if.factor_changed, m_fc);
            check("model_at_min", ctrl_if.at_min, m_factor == 0);
            check("model_at_max", ctrl_if.at_max, m_factor == MAXF);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        ctrl_if.load_en    = 1'b1;
        ctrl_if.load_value = v;
        tick(1);
        ctrl_if.load_en    = 1'b0;
    endtask

    task automatic settle();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(15);
    endtask

    task automatic count_fc(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick(1);
            cnt += int'(ctrl_if.factor_changed);
        end
    endtask

    typedef struct {
        logic [15:0] value;
        logic [15:0] f;
        bit          fc;
        bit          mn;
        bit          mx;
    } load_vec_t;

    load_vec_t vecs[10];

    initial begin
        int cnt;
        int ef;
        vecs[0] = '{16'd5,     16'd5,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'd5,     16'd5,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'd40,    16'd26, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'd26,    16'd26, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'd0,     16'd0,  1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'd0,     16'd0,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'd65535, 16'd26, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'd1,     16'd1,  1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'd25,    16'd25, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{16'd27,    16'd26, 1'b1, 1'b0, 1'b1};

        ctrl_if.load_en    = 1'b0;
        ctrl_if.load_value = '0;
        chk_en = 1'b1;
        tick(3);
        check("rst_factor", ctrl_if.divider_factor, 1);
        check("rst_changed", ctrl_if.factor_changed, 0);
        check("rst_at_min", ctrl_if.at_min, 0);
        check("rst_at_max", ctrl_if.at_max, 0);
        #2 in_rst_n = 1'b1;
        tick(2);
        check("post_rst_factor", ctrl_if.divider_factor, 1);

        // Preset load table
        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].value);
            check($sformatf("load%0d_factor", i), ctrl_if.divider_factor, vecs[i].f);
            check($sformatf("load%0d_changed", i), ctrl_if.factor_changed, vecs[i].fc);
            check($sformatf("load%0d_at_min", i), ctrl_if.at_min, vecs[i].mn);
            check($sformatf("load%0d_at_max", i), ctrl_if.at_max, vecs[i].mx);
            tick(1);
            check($sformatf("load%0d_changed_drop", i), ctrl_if.factor_changed, 0);
        end

        // Bounce rejection then clean press
        do_load(16'd1);
        settle();
        for (int k = 0; k < 5; k++) begin
            btn_up = 1'b1; tick(2);
            btn_up = 1'b0; tick(2);
        end
        check("bounce_reject", ctrl_if.divider_factor, 1);
        btn_up = 1'b1;
        cnt = 0;
        for (int e = 1; e <= 18; e++) begin
            tick(1);
            cnt += int'(ctrl_if.factor_changed);
            if (e == 7) check("bounce_before_step", ctrl_if.divider_factor, 1);
            if (e == 8) begin
                check("bounce_step_changed", ctrl_if.factor_changed, 1);
                check("bounce_step_factor", ctrl_if.divider_factor, 2);
            end
        end
        check("bounce_single_pulse", cnt, 1);
        settle();

        // Reset in the middle of HOLD with the button still held
        btn_up = 1'b1;
        tick(12);
        check("hold_factor", ctrl_if.divider_factor, 3);
        #2 in_rst_n = 1'b0;
        #1;
        check("midhold_rst_factor", ctrl_if.divider_factor, 1);
        check("midhold_rst_changed", ctrl_if.factor_changed, 0);
        tick(1);
        #2 in_rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check("rerelease_factor", ctrl_if.divider_factor, (e < 8) ? 1 : 2);
        end
        check("rerelease_changed", ctrl_if.factor_changed, 1);
        settle();

        // Autorepeat downward from 3 into the lower bound
        do_load(16'd3);
        btn_down = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick(1);
            if (e == 40) btn_down = 1'b0;
            ef = (e < 8) ? 3 : (e < 28) ? 2 : (e < 33) ? 1 : 0;
            check("repeat_factor", ctrl_if.divider_factor, ef);
            check("repeat_changed", ctrl_if.factor_changed, (e == 8 || e == 28 || e == 33) ? 1 : 0);
        end
        check("repeat_at_min", ctrl_if.at_min, 1);
        settle();

        // Step up at the upper bound
        do_load(16'd26);
        btn_up = 1'b1;
        count_fc(35, cnt);
        check("sat_no_changed", cnt, 0);
        check("sat_factor", ctrl_if.divider_factor, 26);
        check("sat_at_max", ctrl_if.at_max, 1);
        settle();

        // Opposing buttons pressed together cancel every step
        do_load(16'd10);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        count_fc(40, cnt);
        check("both_no_changed", cnt, 0);
        check("both_factor", ctrl_if.divider_factor, 10);
        settle();

        // Load coinciding with an up step
        btn_up = 1'b1;
        tick(7);
        ctrl_if.load_en    = 1'b1;
        ctrl_if.load_value = 16'd40;
        tick(1);
        ctrl_if.load_en    = 1'b0;
        check("load_vs_up_factor", ctrl_if.divider_factor, 26);
        check("load_vs_up_changed", ctrl_if.factor_changed, 1);
        count_fc(15, cnt);
        check("load_vs_up_no_more", cnt, 0);
        settle();

        // Equal load
        do_load(16'd5);
        tick(1);
        do_load(16'd5);
        check("equal_load_changed", ctrl_if.factor_changed, 0);
        check("equal_load_factor", ctrl_if.divider_factor, 5);

        // Randomized traffic against the model
        begin
            int run_up   = 0;
            int run_down = 0;
            for (int c = 0; c < 4000; c++) begin
                if (run_up == 0) begin
                    btn_up = ~btn_up;
                    run_up = $urandom_range(1, 45);
                end
                if (run_down == 0) begin
                    btn_down = ~btn_down;
                    run_down = $urandom_range(1, 45);
                end
                run_up--;
                run_down--;
                ctrl_if.load_en    = ($urandom_range(0, 24) == 0);
                ctrl_if.load_value = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
                if ($urandom_range(0, 599) == 0) begin
                    #2 in_rst_n = 1'b0;
                    tick(1);
                    #2 in_rst_n = 1'b1;
                end else begin
                    tick(1);
                end
            end
            ctrl_if.load_en = 1'b0;
            settle();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
